// File: rtl/imm_gen_pipe.sv
// Registered immediate-decode stage: classifies an instruction by opcode, emits the
// sign-extended immediate, format code and tag through a 2-entry skid buffer.
module imm_gen_pipe #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 8,
  parameter int RV64_OPS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (RV64_OPS != 0 && XLEN != 64) begin : g_bad_rv64
      $error("imm_gen_pipe: RV64_OPS requires XLEN=64");
    end
  endgenerate

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       typ;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam logic [2:0] T_I = 3'd0, T_S = 3'd1, T_B = 3'd2, T_U = 3'd3,
                         T_J = 3'd4, T_R = 3'd5, T_ILL = 3'd7;

  state_t state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d, dec;
  logic   in_ready_q, in_ready_d;
  logic   in_fire, out_fire;

  logic        sgn;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] imm32;

  assign sgn   = in_instr[31];
  assign imm_i = {{20{sgn}}, in_instr[31:20]};
  assign imm_s = {{20{sgn}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{sgn}}, sgn, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{sgn}}, sgn, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    imm32   = '0;
    dec     = '0;
    dec.typ = T_ILL;
    dec.ill = 1'b1;
    dec.tag = in_tag;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        dec.typ = T_I; dec.ill = 1'b0; imm32 = imm_i;
      end
      7'b0100011: begin dec.typ = T_S; dec.ill = 1'b0; imm32 = imm_s; end
      7'b1100011: begin dec.typ = T_B; dec.ill = 1'b0; imm32 = imm_b; end
      7'b0110111, 7'b0010111: begin dec.typ = T_U; dec.ill = 1'b0; imm32 = imm_u; end
      7'b1101111: begin dec.typ = T_J; dec.ill = 1'b0; imm32 = imm_j; end
      7'b0110011: begin dec.typ = T_R; dec.ill = 1'b0; end
      7'b0011011: if (RV64_OPS != 0) begin dec.typ = T_I; dec.ill = 1'b0; imm32 = imm_i; end
      7'b0111011: if (RV64_OPS != 0) begin dec.typ = T_R; dec.ill = 1'b0; end
      default: ;
    endcase
    // Every format's immediate fits in 32 bits, so one signed widening covers XLEN=64.
    dec.imm = XLEN'($signed(imm32));
  end

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign in_fire   = in_valid && in_ready_q;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (in_fire) begin
        main_d  = dec;
        state_d = ONE;
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = dec;
        end else if (in_fire) begin
          skid_d  = dec;
          state_d = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: if (out_fire) begin
        main_d  = skid_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign out_imm     = main_q.imm;
  assign out_type    = main_q.typ;
  assign out_illegal = main_q.ill;
  assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an RV32 and an RV64 instance share one stimulus stream,
// each checked by a scoreboard fed from a signed-arithmetic reference model.
module tb_imm_gen_pipe;

  typedef struct {
    longint unsigned imm;
    logic [2:0]      typ;
    logic            ill;
    logic [7:0]      tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_illegal_a;
  logic [31:0] out_imm_a;
  logic [2:0]  out_type_a;
  logic [7:0]  out_tag_a;

  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [63:0] out_imm_b;
  logic [2:0]  out_type_b;
  logic [7:0]  out_tag_b;

  int n_cmp = 0;
  int n_err = 0;
  exp_t q32[$];
  exp_t q64[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .RV64_OPS(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_imm(out_imm_a), .out_type(out_type_a),
    .out_illegal(out_illegal_a), .out_tag(out_tag_a));

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .RV64_OPS(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_imm(out_imm_b), .out_type(out_type_b),
    .out_illegal(out_illegal_b), .out_tag(out_tag_b));

  function automatic exp_t model(input logic [31:0] i, input logic [7:0] t, input bit rv64);
    exp_t e;
    longint v;
    v = 0;
    e.typ = 3'd7;
    e.ill = 1'b1;
    e.tag = t;
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        e.typ = 3'd0; v = longint'($signed(i[31:20]));
      end
      7'b0011011: if (rv64) begin e.typ = 3'd0; v = longint'($signed(i[31:20])); end
      7'b0100011: begin e.typ = 3'd1; v = longint'($signed({i[31:25], i[11:7]})); end
      7'b1100011: begin
        e.typ = 3'd2; v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin e.typ = 3'd3; v = longint'($signed({i[31:12], 12'h000})); end
      7'b1101111: begin
        e.typ = 3'd4; v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      end
      7'b0110011: e.typ = 3'd5;
      7'b0111011: if (rv64) e.typ = 3'd5;
      default: ;
    endcase
    if (e.typ != 3'd7) e.ill = 1'b0;
    e.imm = longint'(unsigned'(v));
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: whatever is presented must match the oldest outstanding entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_a) begin
        if (q32.size() == 0) chk("a_unexpected_valid", 64'd1, 64'd0);
        else begin
          chk("a_imm", {32'd0, out_imm_a}, {32'd0, q32[0].imm[31:0]});
          chk("a_type", {61'd0, out_type_a}, {61'd0, q32[0].typ});
          chk("a_illegal", {63'd0, out_illegal_a}, {63'd0, q32[0].ill});
          chk("a_tag", {56'd0, out_tag_a}, {56'd0, q32[0].tag});
          if (out_ready) void'(q32.pop_front());
        end
      end
      if (out_valid_b) begin
        if (q64.size() == 0) chk("b_unexpected_valid", 64'd1, 64'd0);
        else begin
          chk("b_imm", out_imm_b, q64[0].imm);
          chk("b_type", {61'd0, out_type_b}, {61'd0, q64[0].typ});
          chk("b_illegal", {63'd0, out_illegal_b}, {63'd0, q64[0].ill});
          chk("b_tag", {56'd0, out_tag_b}, {56'd0, q64[0].tag});
          if (out_ready) void'(q64.pop_front());
        end
      end
      if (in_valid && in_ready_a) q32.push_back(model(in_instr, in_tag, 1'b0));
      if (in_valid && in_ready_b) q64.push_back(model(in_instr, in_tag, 1'b1));
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted it.
  task automatic send(input logic [31:0] i, input logic [7:0] t, output int waited);
    in_valid = 1'b1;
    in_instr = i;
    in_tag   = t;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready_a) break;
      waited++;
      if (waited > 200) begin
        chk("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q32.size() != 0 || q64.size() != 0) && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_q32_empty", 64'(q32.size()), 64'd0);
    chk("drain_q64_empty", 64'(q64.size()), 64'd0);
  endtask

  logic [6:0] ops [12] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011,
                           7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011,
                           7'b0011011, 7'b0111011};

  initial begin
    int w;
    bit done;
    logic [31:0] r;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
    #2;
    chk("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready_a}, 64'd1);
    chk("rst_out_imm", out_imm_b, 64'd0);
    chk("rst_out_type", {61'd0, out_type_a}, 64'd0);
    chk("rst_out_illegal", {63'd0, out_illegal_b}, 64'd0);
    chk("rst_out_tag", {56'd0, out_tag_a}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    send(32'hFFF00093, 8'h11, w);
    chk("addi_valid", {63'd0, out_valid_a}, 64'd1);
    chk("addi_imm", {32'd0, out_imm_a}, 64'hFFFF_FFFF);
    chk("addi_tag", {56'd0, out_tag_a}, 64'h11);

    send(32'h12345037, 8'h21, w);
    chk("lui_imm", {32'd0, out_imm_a}, 64'h1234_5000);
    chk("lui_type", {61'd0, out_type_a}, 64'd3);
    send(32'hFE000EE3, 8'h22, w);
    chk("b2b_no_wait_beq", 64'(w), 64'd0);
    chk("beq_imm", {32'd0, out_imm_a}, 64'hFFFF_FFFC);
    chk("beq_type", {61'd0, out_type_a}, 64'd2);
    send(32'h0080006F, 8'h23, w);
    chk("b2b_no_wait_jal", 64'(w), 64'd0);
    chk("jal_imm", {32'd0, out_imm_a}, 64'h8);
    chk("jal_type", {61'd0, out_type_a}, 64'd4);
    @(posedge clk); #1;

    out_ready = 1'b0;
    send(32'h00500113, 8'h31, w);
    send(32'h00A00193, 8'h32, w);
    chk("bp_in_ready_low", {63'd0, in_ready_a}, 64'd0);
    chk("bp_hold_first", {56'd0, out_tag_a}, 64'h31);
    fork
      send(32'hFFF00213, 8'h33, w);
      begin
        repeat (3) @(posedge clk);
        chk("bp_still_held", {32'd0, out_imm_a}, 64'h5);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    send(32'h00000000, 8'h41, w);
    chk("ill_type", {61'd0, out_type_a}, 64'd7);
    chk("ill_flag", {63'd0, out_illegal_a}, 64'd1);
    chk("ill_imm", {32'd0, out_imm_a}, 64'd0);
    send(32'h002081B3, 8'h42, w);
    chk("add_type", {61'd0, out_type_a}, 64'd5);
    chk("add_flag", {63'd0, out_illegal_a}, 64'd0);

    send(32'hFFF0809B, 8'h51, w);
    chk("addiw_imm64", out_imm_b, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addiw_type64", {61'd0, out_type_b}, 64'd0);
    chk("addiw_rv32_illegal", {61'd0, out_type_a}, 64'd7);
    send(32'h800000B7, 8'h52, w);
    chk("lui_imm64", out_imm_b, 64'hFFFF_FFFF_8000_0000);
    chk("lui_imm32", {32'd0, out_imm_a}, 64'h8000_0000);
    drain();

    out_ready = 1'b0;
    send(32'h00100093, 8'h61, w);
    send(32'h00200093, 8'h62, w);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {63'd0, out_valid_b}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready_b}, 64'd1);
    chk("mid_rst_out_imm", out_imm_b, 64'd0);
    q32.delete();
    q64.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    send(32'h00700093, 8'hA5, w);
    chk("post_rst_tag", {56'd0, out_tag_b}, 64'hA5);
    chk("post_rst_imm", out_imm_b, 64'h7);
    drain();

    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          r = $urandom;
          if ($urandom_range(0, 7) == 0) send(r, 8'(n), w);
          else send({r[31:7], ops[$urandom_range(0, 11)]}, 8'(n), w);
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, handshaked immediate-decode stage; parametrised successor to the combinational immediate generator.
- Accepts one 32-bit instruction per cycle and classifies it by opcode.
- Emits a single selected, sign-extended XLEN-wide immediate, its format code, an illegal flag and a pass-through tag.
- Sits between fetch/decode and the operand-select/execute stage; a 2-entry skid buffer gives full throughput under back-pressure.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; immediate sign-extended to XLEN.
TAG_W, 8, width of opaque tag (e.g. PC index) carried alongside each instruction.
RV64_OPS, 0, when 1 (only legal with XLEN=64) also decodes OP-IMM-32 (0011011) as I and OP-32 (0111011) as R.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  upstream instruction valid.
in_ready  output  1  stage can accept; registered.
in_instr  input  32  instruction word.
in_tag  input  TAG_W  tag accompanying instruction.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts.
out_imm  output  XLEN  selected sign-extended immediate.
out_type  output  3  format: 0=I, 1=S, 2=B, 3=U, 4=J, 5=R (no imm), 7=illegal.
out_illegal  output  1  opcode not recognised.
out_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset (async assert, sync release): out_valid=0, in_ready=1, out_imm=0, out_type=0, out_illegal=0, out_tag=0; both buffer entries empty.
- Transfer rules: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- Decode is combinational on in_instr; the result is registered. Latency is 1 cycle: accepted at edge N, visible at out_* after edge N.
- Opcode map (instr[6:0]):
  - 0010011, 0000011, 1100111, 1110011 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111, 0010111 -> U
  - 1101111 -> J
  - 0110011 -> R
  - RV64_OPS adds 0011011 -> I and 0111011 -> R.
  - Any other opcode -> type 7, out_illegal=1.
- Immediates, sign bit instr[31] replicated to XLEN:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'b0}; sign-extended above bit 31 when XLEN=64.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R and illegal produce out_imm=0.
- Buffer: main register (drives out_*) plus skid register.
  - States: EMPTY (main empty), ONE (main full, skid empty), TWO (both full).
  - EMPTY: input accepted -> ONE.
  - ONE:
    - Input accepted without output transfer -> TWO (new entry into skid).
    - Output transfer without input -> EMPTY.
    - Both simultaneous -> stays ONE; main reloads from input.
  - TWO: in_ready=0.
    - Output transfer -> ONE; skid moves to main.
    - Otherwise holds.
- in_ready = registered (state != TWO). No combinational path from out_ready to in_ready.
- out_* stable while out_valid && !out_ready.
- No entry is dropped or duplicated; order is preserved.
- Reset asserted mid-operation: all entries discarded immediately; outputs return to reset values.
- Elaboration error if XLEN is not 32/64, or if RV64_OPS=1 with XLEN=32.

Test Plan:
1. XLEN=32, out_ready=1; send 0xFFF00093 (addi x1,x0,-1), tag 0x11 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_type=0, out_tag=0x11.
2. Back-to-back 0x12345037 (lui), 0xFE000EE3 (beq, -4), 0x0080006F (jal +8), with out_ready=1 every cycle -> consecutive outputs 0x12345000/3, 0xFFFFFFFC/2, 0x00000008/4; in_ready stays 1.
3. Back-pressure: out_ready=0, stream three instructions -> first two accepted, in_ready=0 after second, out_* held on first. Raise out_ready -> all three emerge in order, none lost.
4. Illegal and R-type: 0x00000000 -> out_type=7, out_illegal=1, out_imm=0. 0x002081B3 (add) -> out_type=5, out_imm=0, out_illegal=0.
5. XLEN=64, RV64_OPS=1: 0x8000003B... use 0xFFF0809B (addiw -1) -> out_imm=0xFFFFFFFFFFFFFFFF, type 0. 0x800000B7 (lui) -> 0xFFFFFFFF80000000.
6. Assert rst while in TWO state -> out_valid=0 and in_ready=1 immediately, with no clock edge required; after release the first new instruction emerges with correct tag.
